// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit sequencer.
// Imported by the clock generator and the top-level controller.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam int BITSIZE_DEF   = 16;
  localparam int SLOT_BITS_DEF = 32;
  localparam int BCLK_HALF_DEF = 2;
  localparam int UCNT_W_DEF    = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/i2s_tx_ctrl_if.sv
// Upstream sample-pair handshake into the I2S transmit sequencer.
// The producer drives master, the controller takes slave.
interface i2s_tx_ctrl_if #(
  parameter int BITSIZE = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [BITSIZE-1:0] in_left;
  logic [BITSIZE-1:0] in_right;

  modport master (
    output in_valid, in_left, in_right,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_left, in_right,
    output in_ready
  );
endinterface

// File: rtl/i2s_clkgen.sv
// bclk/lrclk generator: mclk divider, bit counter in the frame,
// and fall/frame strobes for the sequencer.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  parameter int BCLK_HALF = BCLK_HALF_DEF
) (
  input  logic mclk,
  input  logic resetn,
  input  logic en,
  input  logic drain,
  output logic bclk,
  output logic lrclk,
  output logic fall_tick,
  output logic frame_tick
);

  localparam int DW = (clog2(BCLK_HALF) < 1) ? 1 : clog2(BCLK_HALF);
  localparam int BW = clog2(2 * SLOT_BITS);

  localparam logic [DW-1:0] DIV_TC   = DW'(BCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] LR_LO    = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] LR_HI    = BW'(2 * SLOT_BITS - 2);

  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d, bit_nxt;
  logic          bclk_q, bclk_d;
  logic          lr_q, lr_d;
  logic          first_q, first_d;
  logic          tc;

  always_comb begin
    tc         = (div_q == DIV_TC);
    fall_tick  = en && tc && bclk_q;
    // first falling edge after start always opens a frame
    bit_nxt    = (first_q || bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
    frame_tick = fall_tick && (bit_nxt == '0);
    div_d      = div_q;
    bit_d      = bit_q;
    bclk_d     = bclk_q;
    lr_d       = lr_q;
    first_d    = first_q;
    if (!en || (frame_tick && drain)) begin
      div_d   = '0;
      bit_d   = '0;
      bclk_d  = 1'b0;
      lr_d    = 1'b1;
      first_d = 1'b1;
    end else begin
      div_d = tc ? '0 : div_q + 1'b1;
      if (tc) bclk_d = ~bclk_q;
      if (fall_tick) begin
        bit_d   = bit_nxt;
        lr_d    = (bit_nxt >= LR_LO) && (bit_nxt <= LR_HI);
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge mclk or negedge resetn) begin
    if (!resetn) begin
      div_q   <= '0;
      bit_q   <= '0;
      bclk_q  <= 1'b0;
      lr_q    <= 1'b1;
      first_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      bclk_q  <= bclk_d;
      lr_q    <= lr_d;
      first_q <= first_d;
    end
  end

  assign bclk  = bclk_q;
  assign lrclk = lr_q;

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit sequencer: run/drain FSM, one-frame sample buffer,
// frame-aligned word update and saturating underrun counter.
module i2s_tx_ctrl
  import i2s_pkg::*;
#(
  parameter int BITSIZE   = BITSIZE_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  parameter int BCLK_HALF = BCLK_HALF_DEF,
  parameter int UCNT_W    = UCNT_W_DEF
) (
  input  logic               mclk,
  input  logic               resetn,
  input  logic               confdone,
  i2s_tx_ctrl_if.slave       up,
  output logic               bclk,
  output logic               lrclk,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               frame_start,
  output logic [UCNT_W-1:0]  underrun_cnt
);

  state_e             state_q, state_d;
  logic               full_q, full_d;
  logic [BITSIZE-1:0] buf_l_q, buf_l_d;
  logic [BITSIZE-1:0] buf_r_q, buf_r_d;
  logic [BITSIZE-1:0] left_q, left_d;
  logic [BITSIZE-1:0] right_q, right_d;
  logic               fs_q, fs_d;
  logic [UCNT_W-1:0]  ucnt_q, ucnt_d;
  logic               rdy_q, rdy_d;
  logic               clk_en, clk_drain;
  logic               fall_tick, frame_tick;
  logic               frame_end, boundary, xfer;

  always_comb begin
    clk_en    = (state_q != IDLE);
    clk_drain = (state_q == DRAIN);
  end

  i2s_clkgen #(
    .SLOT_BITS (SLOT_BITS),
    .BCLK_HALF (BCLK_HALF)
  ) u_clkgen (
    .mclk       (mclk),
    .resetn     (resetn),
    .en         (clk_en),
    .drain      (clk_drain),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .fall_tick  (fall_tick),
    .frame_tick (frame_tick)
  );

  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    buf_l_d   = buf_l_q;
    buf_r_d   = buf_r_q;
    left_d    = left_q;
    right_d   = right_q;
    ucnt_d    = ucnt_q;
    frame_end = fall_tick && frame_tick;
    boundary  = frame_end && (state_q == RUN);
    xfer      = up.in_valid && rdy_q;
    fs_d      = boundary;

    unique case (state_q)
      IDLE:    if (confdone) state_d = RUN;
      RUN:     if (!confdone) state_d = DRAIN;
      DRAIN:   if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      buf_l_d = up.in_left;
      buf_r_d = up.in_right;
      full_d  = 1'b1;
    end

    if (boundary) begin
      if (full_q) begin
        left_d  = buf_l_q;
        right_d = buf_r_q;
        full_d  = 1'b0;
      end else begin
        left_d  = '0;
        right_d = '0;
        if (ucnt_q != '1) ucnt_d = ucnt_q + 1'b1;
      end
    end

    if (clk_drain && frame_end) begin
      full_d  = 1'b0;
      left_d  = '0;
      right_d = '0;
    end

    // held low through the boundary so a drained buffer reopens a cycle later
    rdy_d = (state_d == RUN) && !full_d && !boundary;
  end

  always_ff @(posedge mclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      full_q  <= 1'b0;
      buf_l_q <= '0;
      buf_r_q <= '0;
      left_q  <= '0;
      right_q <= '0;
      fs_q    <= 1'b0;
      ucnt_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      buf_l_q <= buf_l_d;
      buf_r_q <= buf_r_d;
      left_q  <= left_d;
      right_q <= right_d;
      fs_q    <= fs_d;
      ucnt_q  <= ucnt_d;
      rdy_q   <= rdy_d;
    end
  end

  assign up.in_ready   = rdy_q;
  assign left_chan     = left_q;
  assign right_chan    = right_q;
  assign frame_start   = fs_q;
  assign underrun_cnt  = ucnt_q;

endmodule

// File: doc/i2s_tx_ctrl.md
Name: i2s_tx_ctrl

Overview:
- Sequencer for the I2S transmit serializer; runs in the codec master-clock domain.
- Generates bclk and lrclk from mclk and starts them only once codec configuration completes.
- Accepts stereo samples from upstream over a valid/ready handshake and buffers one frame.
- Presents stable left/right words to the serializer, swapping them only at frame boundaries; inserts silence and counts underruns when upstream is late.

Parameters:
- BITSIZE, 16: sample width per channel.
- SLOT_BITS, 32: bclk periods per channel slot; must be ≥ BITSIZE.
- BCLK_HALF, 2: mclk cycles per bclk half-period; ≥ 1. Defaults give mclk = 256·fs.
- UCNT_W, 16: underrun counter width.

Ports:
- mclk  in  1  system clock (codec master clock).
- resetn  in  1  asynchronous active-low reset.
- confdone  in  1  codec configuration complete; level.
- in_valid  in  1  upstream sample pair valid.
- in_ready  out  1  controller can accept a pair.
- in_left  in  BITSIZE  left sample.
- in_right  in  BITSIZE  right sample.
- bclk  out  1  bit clock to codec/serializer.
- lrclk  out  1  word select; 0 = left, 1 = right.
- left_chan  out  BITSIZE  left word to serializer.
- right_chan  out  BITSIZE  right word to serializer.
- frame_start  out  1  one-mclk pulse when left_chan/right_chan update.
- underrun_cnt  out  UCNT_W  saturating count of silent frames.

Behaviour:
- Reset values: bclk=0, lrclk=1, left_chan=0, right_chan=0, frame_start=0, underrun_cnt=0, in_ready=0, state=IDLE, buffer empty, div_cnt=0, bit_cnt=0.
- Reset is asynchronous and active-low. Assertion mid-frame stops the clocks immediately; the buffer contents are discarded.
- States:
  - IDLE: clocks held at reset values; in_ready=0. Goes to RUN when confdone=1.
  - RUN: clocks toggle; in_ready = buffer empty. Goes to DRAIN when confdone=0.
  - DRAIN: clocks continue until the current frame ends (bit_cnt wrap), then go to IDLE. bclk ends low, lrclk high, outputs zeroed, buffer flushed, underrun_cnt kept.
- Clock generation (RUN/DRAIN only):
  - div_cnt counts 0..BCLK_HALF-1; at terminal count it wraps and bclk toggles.
  - On each bclk falling toggle, bit_cnt advances mod 2·SLOT_BITS.
  - lrclk updates on falling toggles to 1 when next bit_cnt ∈ [SLOT_BITS-1, 2·SLOT_BITS-2], else 0. This gives the I2S one-bit lead before the MSB.
- First frame: the first falling toggle after IDLE→RUN sets bit_cnt=0; that mclk is a frame boundary.
- Frame boundary = mclk cycle in which bit_cnt becomes 0 on a falling toggle. On it:
  - frame_start=1 for that cycle.
  - Buffer full: left_chan/right_chan take the buffer contents; buffer becomes empty.
  - Buffer empty: both outputs load 0; underrun_cnt increments and saturates at all-ones.
- Handshake:
  - A transfer occurs when in_valid && in_ready at a rising mclk edge.
  - A transfer and a frame-boundary drain in the same cycle are not possible, because in_ready=0 while the buffer is full.
  - in_ready is registered. It rises on the mclk after a drain, so a pair offered in the boundary cycle is accepted one cycle later.
  - Upstream may hold in_valid indefinitely; data must stay stable until accepted.
- confdone falling while in_valid is high: no further acceptance after entering DRAIN.
- Width rules:
  - Samples are passed unmodified.
  - underrun_cnt uses unsigned saturating add.
  - bit_cnt width is clog2(2·SLOT_BITS).
  - div_cnt width is clog2(BCLK_HALF), minimum 1.

Decomposition:
- Shared package i2s_pkg:
  - state enum (IDLE, RUN, DRAIN).
  - default BITSIZE/SLOT_BITS/BCLK_HALF constants.
  - clog2 helper.
- One natural sub-module, i2s_clkgen: div_cnt, bit_cnt, bclk, lrclk, plus fall_tick/frame_tick strobes.
- Buffer, FSM and counter stay in the top.

Test Plan:
- Reset release, confdone=0 for 100 mclk -> bclk=0, lrclk=1, in_ready=0, outputs 0, no frame_start.
- confdone=1, defaults -> bclk period 4 mclk; 64 bclk periods per frame; lrclk period 256 mclk; lrclk falls 1 bclk before slot start.
- Upstream supplies 0x1234/0xABCD before the first boundary -> at frame_start left_chan=0x1234, right_chan=0xABCD; in_ready returns high the next mclk.
- Upstream pairs supplied with no gaps for 8 frames (0x0001..0x0008) -> each frame_start shows the next pair in order; underrun_cnt=0.
- Upstream stalls for 3 frames -> outputs 0 for those frames; underrun_cnt=3; next supplied pair appears at the following boundary.
- Behaviour checks:
  - confdone drops mid-frame -> clocks continue to bit_cnt wrap, then IDLE with lrclk=1, outputs 0.
  - resetn pulsed low mid-frame -> all outputs at reset values within the same cycle.
  - UCNT_W=2 with 5 underruns -> counter holds 3.
